// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin on simultaneous requests, grant locked for the whole cycle.
// Optional bus watchdog enabled with `define WB_ARB_TIMEOUT_EN (error pulse after TIMEOUT stalled cycles).
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    // master 0
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    // master 1
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    // shared slave
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    output logic [1:0]        grant_o
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_reg, state_next;
    logic   last_reg, last_next;    // 0: master 0 granted last, 1: master 1

    logic [1:0]    own;
    logic [1:0]    ack_vec;
    logic [1:0]    err_vec;
    logic [1:0]    cyc_in;
    logic [1:0]    stb_in;
    logic [1:0]    we_in;
    logic [AW-1:0] adr_in [2];
    logic [DW-1:0] dat_in [2];
    logic [SW-1:0] sel_in [2];
    logic          owner_cyc;
    logic          owner_stb;
    logic          timeout_hit;

    assign cyc_in    = {m1_cyc_i, m0_cyc_i};
    assign stb_in    = {m1_stb_i, m0_stb_i};
    assign we_in     = {m1_we_i, m0_we_i};
    assign adr_in[0] = m0_adr_i;
    assign adr_in[1] = m1_adr_i;
    assign dat_in[0] = m0_dat_i;
    assign dat_in[1] = m1_dat_i;
    assign sel_in[0] = m0_sel_i;
    assign sel_in[1] = m1_sel_i;

    // Outputs are also held quiet while reset is asserted, not just after its edge.
    assign own[0]  = (state_reg == GNT0) && !reset;
    assign own[1]  = (state_reg == GNT1) && !reset;
    assign grant_o = own;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_reg)) begin
                    state_next = GNT0;
                    last_next  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                    last_next  = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc_i) state_next = IDLE;
            GNT1:    if (!m1_cyc_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (own[i]) begin
                s_adr_o   = adr_in[i];
                s_dat_o   = dat_in[i];
                s_sel_o   = sel_in[i];
                s_we_o    = we_in[i];
                owner_cyc = cyc_in[i];
                owner_stb = stb_in[i];
            end
        end
    end

    // A watchdog expiry drops the bus strobe for that one cycle so the slave sees the abort.
    assign s_cyc_o = owner_cyc && !timeout_hit;
    assign s_stb_o = owner_stb && !timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] cnt_reg, cnt_next;
    logic       stall;

    assign stall       = owner_stb && !s_ack_i && !s_err_i;
    assign timeout_hit = (|own) && (cnt_reg == 8'(TIMEOUT));

    always_comb begin
        cnt_next = '0;
        if (!timeout_hit && stall) cnt_next = cnt_reg + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign ack_vec[gi] = own[gi] && s_ack_i;
        assign err_vec[gi] = own[gi] && (s_err_i || timeout_hit);
    end

    assign m0_ack_o = ack_vec[0];
    assign m1_ack_o = ack_vec[1];
    assign m0_err_o = err_vec[0];
    assign m1_err_o = err_vec[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width; select width is DW/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum unacknowledged cycles, range 1..255.
REQ-004 SHALL have port clock, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have, for each N in {0,1}, inputs mN_adr_i (AW), mN_dat_i (DW), mN_sel_i (DW/8), mN_we_i (1), mN_cyc_i (1), mN_stb_i (1): master N request side.
REQ-007 SHALL have, for each N, outputs mN_dat_o (DW), mN_ack_o (1), mN_err_o (1): master N response side.
REQ-008 SHALL have outputs s_adr_o (AW), s_dat_o (DW), s_sel_o (DW/8), s_we_o, s_cyc_o, s_stb_o: shared slave request side.
REQ-009 SHALL have inputs s_dat_i (DW), s_ack_i (1), s_err_i (1): shared slave response side.
REQ-010 SHALL have output grant_o, 2 bits, one-hot current owner, 00 when idle.

Function
REQ-011 SHALL implement a registered FSM with states IDLE, GNT0, GNT1.
REQ-012 In IDLE, a single asserted mN_cyc_i SHALL cause transition to GNTN on the next edge.
REQ-013 In IDLE with both cyc asserted, the grant SHALL go to the master not most recently granted; the last-owner register SHALL update on each grant.
REQ-014 In GNTN, the FSM SHALL remain in GNTN while mN_cyc_i is high, regardless of the other master; the lock covers block and RMW cycles.
REQ-015 In GNTN, mN_cyc_i low SHALL return the FSM to IDLE on the next edge; a new grant SHALL then take at least one further cycle (one dead cycle between owners).
REQ-016 In GNTN, s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o SHALL equal master N's inputs combinationally.
REQ-017 In IDLE, all s_* outputs SHALL be 0.
REQ-018 mN_ack_o and mN_err_o SHALL equal s_ack_i and s_err_i gated by GNTN; the non-owner SHALL see 0.
REQ-019 m0_dat_o and m1_dat_o SHALL both be driven from s_dat_i.
REQ-020 Latency SHALL be one cycle from mN_cyc_i rising (IDLE) to s_cyc_o rising; zero added latency on stb/ack inside a grant.
REQ-021 grant_o SHALL be 01 in GNT0, 10 in GNT1, 00 in IDLE.

Reset
REQ-022 reset SHALL force state IDLE and last-owner to master 1, so master 0 wins the first simultaneous request.
REQ-023 During and after reset, all s_* outputs, all mN_ack_o/mN_err_o, grant_o and the timeout counter SHALL be 0.
REQ-024 reset mid-transfer SHALL abort the grant on the next edge with no ack or err issued to the owner.

Configuration
REQ-025 Macro WB_ARB_TIMEOUT_EN SHALL enable the bus watchdog.
REQ-026 With WB_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL increment each granted cycle with s_stb_o high and s_ack_i, s_err_i low; it SHALL clear on ack, err, stb low or leaving the grant.
REQ-027 When the counter equals TIMEOUT, the owner's mN_err_o SHALL be 1 for that cycle, s_cyc_o and s_stb_o SHALL be forced to 0 that cycle, and the counter SHALL clear.
REQ-028 Without WB_ARB_TIMEOUT_EN: no counter SHALL exist; a stalled slave SHALL hold the grant indefinitely.

Verification
REQ-029 Reset, then m0_cyc_i=m1_cyc_i=1 in the same cycle -> grant_o=01 one cycle later; m0 drops cyc -> IDLE for one cycle, then grant_o=10.
REQ-030 m1 owns, m1 issues 4 stb cycles with s_ack_i, m0 raises cyc mid-burst -> all 4 acks reach m1 only, m0_ack_o stays 0, m0 is granted after m1 drops cyc.
REQ-031 Alternating back-to-back requests over 6 transactions with both cyc held -> grants alternate 01,10,01,10,01,10.
REQ-032 m0 owns, s_err_i=1 on a write to adr 0x8000_0000 -> m0_err_o=1 same cycle, m1_err_o=0.
REQ-033 WB_ARB_TIMEOUT_EN, TIMEOUT=16, slave never acks -> m0_err_o pulses after 16 stalled cycles, s_stb_o low that cycle; without the macro -> no err after 1000 cycles.
REQ-034 reset asserted while m0 is granted with stb high -> next cycle grant_o=00, s_cyc_o=0, m0_ack_o=m0_err_o=0.
